// File: rtl/component_alu_writeback_buffer.sv
// component_alu_writeback_buffer
// Two-entry elastic buffer between the execute ALU and writeback. Holds each ALU
// result with its flags and register-write control, presents entries in FIFO order
// over valid/ready, and keeps the architectural {N,C,Z} flags, which update only
// when a flag-setting entry is popped.
module component_alu_writeback_buffer #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  input_Clock,
    input  logic                  input_ResetN,
    input  logic                  input_Valid,
    output logic                  output_Ready,
    input  logic [DATA_W-1:0]     input_Result,
    input  logic                  input_ZeroFlag,
    input  logic                  input_CarryFlag,
    input  logic [REG_ADDR_W-1:0] input_DestReg,
    input  logic                  input_WriteEn,
    input  logic                  input_SetFlags,
    input  logic                  input_Flush,
    output logic                  output_Valid,
    input  logic                  input_Ready,
    output logic [DATA_W-1:0]     output_Result,
    output logic [REG_ADDR_W-1:0] output_DestReg,
    output logic                  output_WriteEn,
    output logic [2:0]            output_Flags,
    output logic [2:0]            output_StatusFlags,
    output logic [1:0]            output_Occupancy
);

    logic [DATA_W-1:0]     r_result [2];
    logic [REG_ADDR_W-1:0] r_dest   [2];
    logic                  r_we     [2];
    logic [2:0]            r_flags  [2];
    logic                  r_setf   [2];

    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic [2:0]            r_status;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_store;

    // Handshake decode uses registered occupancy only, so Ready never depends on input_Ready.
    assign output_Valid     = (r_count != 2'd0);
    assign output_Ready     = (r_count != 2'd2);
    assign output_Occupancy = r_count;

    assign w_push  = input_Valid && output_Ready;
    assign w_pop   = output_Valid && input_Ready;
    // A flush discards any push arriving in the same cycle.
    assign w_store = w_push && !input_Flush;

    assign output_Result      = r_result[r_rd_ptr];
    assign output_DestReg     = r_dest[r_rd_ptr];
    assign output_WriteEn     = r_we[r_rd_ptr];
    assign output_Flags       = r_flags[r_rd_ptr];
    assign output_StatusFlags = r_status;

    // Entry storage: write the slot under the write pointer on an accepted push.
    always_ff @(posedge input_Clock or negedge input_ResetN) begin
        if (!input_ResetN) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_result[i] <= '0;
                r_dest[i]   <= '0;
                r_we[i]     <= 1'b0;
                r_flags[i]  <= '0;
                r_setf[i]   <= 1'b0;
            end
        end else if (w_store) begin
            r_result[r_wr_ptr] <= input_Result;
            r_dest[r_wr_ptr]   <= input_DestReg;
            r_we[r_wr_ptr]     <= input_WriteEn;
            r_flags[r_wr_ptr]  <= {input_Result[DATA_W-1], input_CarryFlag, input_ZeroFlag};
            r_setf[r_wr_ptr]   <= input_SetFlags;
        end
    end

    // Pointers and occupancy; flush empties the buffer and rewinds both pointers.
    always_ff @(posedge input_Clock or negedge input_ResetN) begin
        if (!input_ResetN) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (input_Flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            r_wr_ptr <= r_wr_ptr ^ w_push;
            r_rd_ptr <= r_rd_ptr ^ w_pop;
            r_count  <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Architectural flags retire from the head on a pop, including a pop coincident with flush.
    always_ff @(posedge input_Clock or negedge input_ResetN) begin
        if (!input_ResetN) begin
            r_status <= 3'b000;
        end else if (w_pop && r_setf[r_rd_ptr]) begin
            r_status <= r_flags[r_rd_ptr];
        end
    end

endmodule

// File: tb/tb_component_alu_writeback_buffer.sv
// Self-checking bench for component_alu_writeback_buffer: directed scenarios followed
// by random traffic, all compared against a queue-based reference model.
module tb_component_alu_writeback_buffer;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  out_ready;
    logic [DATA_W-1:0]     in_result = '0;
    logic                  in_z = 1'b0;
    logic                  in_c = 1'b0;
    logic [REG_ADDR_W-1:0] in_dest = '0;
    logic                  in_we = 1'b0;
    logic                  in_sf = 1'b0;
    logic                  in_flush = 1'b0;
    logic                  out_valid;
    logic                  in_ready = 1'b0;
    logic [DATA_W-1:0]     out_result;
    logic [REG_ADDR_W-1:0] out_dest;
    logic                  out_we;
    logic [2:0]            out_flags;
    logic [2:0]            out_status;
    logic [1:0]            out_occ;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  dest;
        logic        we;
        logic [2:0]  flags;
        logic        setf;
    } ent_t;

    ent_t       q[$];
    logic [2:0] m_status = 3'b000;

    component_alu_writeback_buffer #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) dut (
        .input_Clock        (clk),
        .input_ResetN       (rst_n),
        .input_Valid        (in_valid),
        .output_Ready       (out_ready),
        .input_Result       (in_result),
        .input_ZeroFlag     (in_z),
        .input_CarryFlag    (in_c),
        .input_DestReg      (in_dest),
        .input_WriteEn      (in_we),
        .input_SetFlags     (in_sf),
        .input_Flush        (in_flush),
        .output_Valid       (out_valid),
        .input_Ready        (in_ready),
        .output_Result      (out_result),
        .output_DestReg     (out_dest),
        .output_WriteEn     (out_we),
        .output_Flags       (out_flags),
        .output_StatusFlags (out_status),
        .output_Occupancy   (out_occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output with the model; data fields only when valid.
    task automatic check_all(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'(q.size() != 0));
        chk({tag, "_ready"}, 64'(out_ready), 64'(q.size() < 2));
        chk({tag, "_occ"},   64'(out_occ),   64'(q.size()));
        chk({tag, "_status"}, 64'(out_status), 64'(m_status));
        if (q.size() != 0) begin
            chk({tag, "_result"}, 64'(out_result), 64'(q[0].res));
            chk({tag, "_dest"},   64'(out_dest),   64'(q[0].dest));
            chk({tag, "_we"},     64'(out_we),     64'(q[0].we));
            chk({tag, "_flags"},  64'(out_flags),  64'(q[0].flags));
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic z, input logic c,
                         input logic [4:0] dest, input logic we, input logic sf,
                         input logic fl, input logic rdy);
        in_valid  = v;
        in_result = res;
        in_z      = z;
        in_c      = c;
        in_dest   = dest;
        in_we     = we;
        in_sf     = sf;
        in_flush  = fl;
        in_ready  = rdy;
    endtask

    // Advance one clock: predict from the inputs seen before the edge, then check after it.
    task automatic tick(input string tag);
        ent_t e;
        bit   do_push;
        bit   do_pop;
        do_push = in_valid && (q.size() < 2);
        do_pop  = (q.size() != 0) && in_ready;
        e.res   = in_result;
        e.dest  = in_dest;
        e.we    = in_we;
        e.flags = {in_result[31], in_c, in_z};
        e.setf  = in_sf;
        @(posedge clk);
        #1;
        if (do_pop) begin
            if (q[0].setf) m_status = q[0].flags;
            void'(q.pop_front());
        end
        if (in_flush) q.delete();
        else if (do_push) q.push_back(e);
        check_all(tag);
    endtask

    initial begin
        // Reset state
        #2;
        check_all("reset");
        chk("reset_result", 64'(out_result), 64'd0);
        chk("reset_flags",  64'(out_flags),  64'd0);
        #10 rst_n = 1'b1;
        @(negedge clk);

        // Single pass-through
        drive(1, 32'h0000_0005, 0, 0, 5'd3, 1, 1, 0, 1);
        tick("pt_push");
        chk("pt_flags_const", 64'(out_flags), 64'd0);
        drive(0, '0, 0, 0, 0, 0, 0, 0, 1);
        tick("pt_pop");
        chk("pt_status_const", 64'(out_status), 64'd0);

        // Backpressure and fill
        drive(1, 32'h1, 0, 0, 5'd1, 1, 0, 0, 0);
        tick("bp_a");
        drive(1, 32'h2, 0, 0, 5'd2, 1, 0, 0, 0);
        tick("bp_b");
        chk("bp_ready_full", 64'(out_ready), 64'd0);
        drive(1, 32'h3, 0, 0, 5'd4, 1, 0, 0, 0);
        tick("bp_c_refused");
        chk("bp_head_a", 64'(out_result), 64'h1);
        drive(0, '0, 0, 0, 0, 0, 0, 0, 1);
        tick("bp_pop_a");
        chk("bp_head_b", 64'(out_result), 64'h2);
        chk("bp_ready_back", 64'(out_ready), 64'd1);
        tick("bp_pop_b");

        // Flags retire only on SetFlags
        drive(1, 32'h8000_0000, 0, 1, 5'd7, 1, 1, 0, 1);
        tick("fl_push1");
        drive(0, '0, 0, 0, 0, 0, 0, 0, 1);
        tick("fl_pop1");
        chk("fl_status_110", 64'(out_status), 64'b110);
        drive(1, 32'h0, 1, 0, 5'd8, 1, 0, 0, 1);
        tick("fl_push2");
        drive(0, '0, 0, 0, 0, 0, 0, 0, 1);
        tick("fl_pop2");
        chk("fl_status_hold", 64'(out_status), 64'b110);

        // Flush at occupancy 2 with a concurrent push
        drive(1, 32'h0, 1, 0, 5'd9, 1, 1, 0, 0);
        tick("fs_a");
        drive(1, 32'hFFFF_FFFF, 0, 1, 5'd10, 1, 1, 0, 0);
        tick("fs_b");
        drive(1, 32'h1234, 0, 0, 5'd11, 1, 1, 1, 0);
        tick("fs_flush");
        chk("fs_occ0", 64'(out_occ), 64'd0);
        chk("fs_status_unch", 64'(out_status), 64'b110);

        // Flush coincident with a pop
        drive(1, 32'h0, 1, 0, 5'd12, 1, 1, 0, 0);
        tick("fp_push");
        drive(0, '0, 0, 0, 0, 0, 0, 1, 1);
        tick("fp_flushpop");
        chk("fp_status_001", 64'(out_status), 64'b001);
        drive(0, '0, 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-operation at occupancy 2
        drive(1, 32'h8000_0001, 0, 1, 5'd13, 1, 1, 0, 1);
        tick("ar_set");
        drive(1, 32'h55, 0, 0, 5'd14, 0, 0, 0, 0);
        tick("ar_a");
        drive(1, 32'h66, 1, 1, 5'd15, 1, 1, 0, 0);
        tick("ar_b");
        drive(0, '0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        q.delete();
        m_status = 3'b000;
        check_all("ar_async");
        @(negedge clk);
        rst_n = 1'b1;
        tick("ar_after");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 99) < 60), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 5),
                  1'($urandom_range(0, 99) < 55));
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
